// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch resolution path.
package bpu_pkg;

   localparam int XLEN       = 32;
   localparam int INSN_BYTES = 4;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } bpu_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            taken;
      logic [XLEN-1:0] target;
   } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of outstanding branch predictions with a one-cycle flush.
module pred_fifo
   import bpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  pred_entry_t                din,
   input  logic                       pop,
   input  logic                       flush,
   output pred_entry_t                head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   pred_entry_t   mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count = wr_ptr_q - rd_ptr_q;
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks execute outcomes against queued predictions; redirects and flushes on a mispredict.
module branch_resolve_unit
   import bpu_pkg::*;
#(
   parameter int XLEN           = bpu_pkg::XLEN,
   parameter int DEPTH          = 4,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pred_valid,
   output logic                       pred_ready,
   input  logic [XLEN-1:0]            pred_pc,
   input  logic                       pred_taken,
   input  logic [XLEN-1:0]            pred_target,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic [XLEN-1:0]            res_target,
   output logic                       mispredict,
   output logic [XLEN-1:0]            redirect_pc,
   output logic                       recovering,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic                       err_orphan
);

   localparam int CW = $clog2(RECOVER_CYCLES + 1);

   // Handshake: a prediction record transfers on any rising edge where
   // pred_valid & pred_ready; pred_ready depends only on registered state.

   bpu_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mispredict_q, mispredict_d;
   logic [XLEN-1:0] redirect_q, redirect_d;
   logic            err_q, err_d;

   pred_entry_t     new_entry, head;
   logic            fifo_full, fifo_empty;
   logic            push, pop, flush;
   logic            resolve, mis;
   logic [XLEN-1:0] correct_pc;

   assign new_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};
   assign pred_ready = (state_q == ST_RUN) && !fifo_full;
   assign push       = pred_valid && pred_ready;

   assign resolve    = (state_q == ST_RUN) && res_valid && !fifo_empty;
   assign correct_pc = res_taken ? res_target : head.pc + XLEN'(INSN_BYTES);
   assign mis        = resolve &&
                       ((head.taken != res_taken) || (res_taken && (head.target != res_target)));
   assign pop        = resolve && !mis;
   assign flush      = mis;

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .din   (new_entry),
      .pop   (pop),
      .flush (flush),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (outstanding)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mispredict_d = mis;
      redirect_d   = mis ? correct_pc : redirect_q;
      err_d        = err_q || ((state_q == ST_RUN) && res_valid && fifo_empty);
      case (state_q)
         ST_RUN: begin
            if (mis) begin
               state_d = ST_RECOVER;
               cnt_d   = CW'(RECOVER_CYCLES);
            end
         end
         ST_RECOVER: begin
            // The final recovery cycle is the one that sees a count of 1.
            if (cnt_q == CW'(1)) state_d = ST_RUN;
            else                 cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_RUN;
         cnt_q        <= '0;
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mispredict_q <= mispredict_d;
         redirect_q   <= redirect_d;
         err_q        <= err_d;
      end
   end

   assign mispredict  = mispredict_q;
   assign redirect_pc = redirect_q;
   assign recovering  = (state_q == ST_RECOVER);
   assign err_orphan  = err_q;

endmodule
